robo_sequenciador_movimento: RTL
================================

Name: robo_sequenciador_movimento

Overview:
- Timed motion sequencer between the wall-following decision FSM and the two drive motors.
- Accepts one movement command at a time (advance or rotate) on a valid/ready handshake.
- Drives the differential motor enables for a fixed cycle count, then holds a settle pause and reports completion.
- Aborts a forward move when the head sensor fires.

Parameters:
- PASSO_CICLOS, 8: cycles motors are driven for one forward command; must be ≥1.
- GIRO_CICLOS, 12: cycles motors are driven for one rotate command; must be ≥1.
- PAUSA_CICLOS, 2: settle cycles with motors off after any move; must be ≥1.
- CNT_W, 8: timer width; must hold max(PASSO_CICLOS, GIRO_CICLOS, PAUSA_CICLOS).

Ports:
- clock  in  1  system clock; all state changes on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_avancar  in  1  command is advance.
- cmd_girar  in  1  command is rotate.
- head  in  1  front obstacle sensor; 1 = wall ahead.
- motor_esq  out  1  left motor enable.
- motor_dir  out  1  right motor enable.
- done  out  1  one-cycle completion pulse.
- abortado  out  1  valid with done; the completed forward move was cut short by head.
- cmd_erro  out  1  valid with done; the command had neither bit set.
- travado  out  1  sticky stall flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-low): state OCIOSO; timer 0; done, abortado, cmd_erro and travado all 0. Motors are 0 immediately because they are decoded from the state register.
- States: OCIOSO, AVANCANDO, GIRANDO, PAUSA (2-bit encoding).
- Motor decode:
  - AVANCANDO: esq=1, dir=1.
  - GIRANDO: esq=1, dir=0.
  - OCIOSO and PAUSA: 00.
- cmd_ready is 1 only in OCIOSO. A command is accepted on the falling edge where cmd_valid & cmd_ready.
- On accept:
  - cmd_girar=1 goes to GIRANDO and loads timer with GIRO_CICLOS-1. Rotate wins when both bits are set.
  - cmd_avancar=1 only goes to AVANCANDO and loads PASSO_CICLOS-1.
  - Neither bit set: stay in OCIOSO; on the next cycle done=1 and cmd_erro=1; no motion.
- AVANCANDO / GIRANDO: timer decrements each edge. At timer==0 go to PAUSA and load PAUSA_CICLOS-1. The motors are therefore on for exactly PASSO_CICLOS or GIRO_CICLOS cycles.
- Abort: if head==1 is sampled in AVANCANDO, go to PAUSA on that edge, load PAUSA_CICLOS-1 and latch the abort flag. If head rises in the same cycle the timer reaches 0, the move still counts as aborted. head is ignored in GIRANDO, PAUSA and OCIOSO.
- PAUSA: at timer==0 return to OCIOSO. done=1 for exactly the first OCIOSO cycle, with abortado/cmd_erro valid alongside it; both read 0 when done=0.
- Back-to-back commands are allowed: a command may be accepted in the cycle where done=1.
- cmd_avancar/cmd_girar are sampled only at accept; later changes have no effect.
- Reset mid-operation: motion stops at once and no done is issued for the interrupted command.

Optional Feature:
- Macro ROBO_WATCHDOG_EN.
- Defined:
  - A 2-bit counter counts consecutive aborted forward moves, saturating at 3.
  - When the third consecutive abort completes, travado is set together with done. It is sticky.
  - A non-aborted forward completion clears both the counter and travado.
  - Rotate and cmd_erro completions leave them unchanged.
  - Reset clears both.
- Not defined: travado is tied to 0 and no counter logic is present. The port exists in both builds.

Decomposition:
- Package robo_pkg holds:
  - the state encoding constants (OCIOSO=2'b00, AVANCANDO=2'b01, GIRANDO=2'b10, PAUSA=2'b11);
  - the motor pattern constants (PARADO=2'b00, FRENTE=2'b11, GIRO=2'b10).
- Sub-module robo_temporizador: CNT_W down-counter with load, value and zero flag, async active-low reset, falling-edge clock.

Test Plan:
- Forward accepted on edge E0 → motors 11 in cycles 1–8, 00 in cycles 9–10, done=1 in cycle 11 with abortado=0, cmd_ready=1 in cycle 11.
- Rotate accepted on E0 → motors 10 in cycles 1–12, 00 in cycles 13–14, done in cycle 15.
- Forward on E0 with head=1 in cycle 4 → motors 11 in cycles 1–4, 00 from cycle 5, done in cycle 7 with abortado=1.
- cmd_avancar=1 and cmd_girar=1 together → rotate timing (12 cycles, pattern 10). Neither bit set → done with cmd_erro=1 in cycle 1, motors stay 00.
- Reset low in cycle 6 of a rotate → motors 00 and cmd_ready=1 immediately; no done; a new forward afterwards runs with full 8-cycle timing.
- With ROBO_WATCHDOG_EN defined:
  - three aborted forwards → travado=1 at the third done;
  - a rotate leaves it at 1;
  - a clean forward clears it.
  - Without the macro, travado stays 0 throughout.

Source files
------------

// File: rtl/robo_sequenciador_movimento_pkg.sv
// Shared encodings for the motion sequencer: FSM states, motor patterns
// and the state-to-motor decode used by the top level.
package robo_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        AVANCANDO = 2'b01,
        GIRANDO   = 2'b10,
        PAUSA     = 2'b11
    } estado_t;

    // Motor patterns are {esq, dir}.
    localparam logic [1:0] PARADO = 2'b00;
    localparam logic [1:0] FRENTE = 2'b11;
    localparam logic [1:0] GIRO   = 2'b10;

    function automatic logic [1:0] padrao_motor(input estado_t estado);
        logic [1:0] padrao;
        padrao = PARADO;
        case (estado)
            AVANCANDO: padrao = FRENTE;
            GIRANDO:   padrao = GIRO;
            default:   padrao = PARADO;
        endcase
        return padrao;
    endfunction

endpackage

// File: rtl/robo_sequenciador_movimento_temporizador.sv
// Loadable down-counter that stops at zero; falling-edge clocked with an
// asynchronous active-low reset, exposing its value and a zero flag.
module robo_temporizador #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carga_i,
    input  logic [CNT_W-1:0] valor_carga_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] valor_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cont_q;
    logic [CNT_W-1:0] cont_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        cont_d = cont_q;
        if (carga_i) begin
            cont_d = valor_carga_i;
        end else if (dec_i && (cont_q != '0)) begin
            cont_d = cont_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign valor_o = cont_q;
    assign zero_o  = (cont_q == '0);

endmodule

// File: rtl/robo_sequenciador_movimento.sv
// Timed motion sequencer: runs one advance/rotate command, settles, then
// pulses done. Define ROBO_WATCHDOG_EN to build the repeated-abort stall flag.
module robo_sequenciador_movimento
    import robo_pkg::*;
#(
    parameter int PASSO_CICLOS = 8,
    parameter int GIRO_CICLOS  = 12,
    parameter int PAUSA_CICLOS = 2,
    parameter int CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_avancar,
    input  logic cmd_girar,
    input  logic head,
    output logic motor_esq,
    output logic motor_dir,
    output logic done,
    output logic abortado,
    output logic cmd_erro,
    output logic travado
);

    localparam logic [CNT_W-1:0] CARGA_PASSO = CNT_W'(PASSO_CICLOS - 1);
    localparam logic [CNT_W-1:0] CARGA_GIRO  = CNT_W'(GIRO_CICLOS - 1);
    localparam logic [CNT_W-1:0] CARGA_PAUSA = CNT_W'(PAUSA_CICLOS - 1);

    estado_t          estado_q;
    logic             abort_q;
    logic             done_q;
    logic             abortado_q;
    logic             erro_q;

    logic             aceita;
    logic             tmr_carga;
    logic [CNT_W-1:0] tmr_valor_carga;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_valor;
    logic             tmr_zero;

    assign cmd_ready = (estado_q == OCIOSO);
    assign aceita    = cmd_valid && cmd_ready;

    // Motors come straight from the state register, so a reset stops them at once.
    assign {motor_esq, motor_dir} = padrao_motor(estado_q);

    always_comb begin
        tmr_carga       = 1'b0;
        tmr_valor_carga = '0;
        tmr_dec         = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (aceita && cmd_girar) begin
                    tmr_carga       = 1'b1;
                    tmr_valor_carga = CARGA_GIRO;
                end else if (aceita && cmd_avancar) begin
                    tmr_carga       = 1'b1;
                    tmr_valor_carga = CARGA_PASSO;
                end
            end
            AVANCANDO: begin
                if (head || tmr_zero) begin
                    tmr_carga       = 1'b1;
                    tmr_valor_carga = CARGA_PAUSA;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GIRANDO: begin
                if (tmr_zero) begin
                    tmr_carga       = 1'b1;
                    tmr_valor_carga = CARGA_PAUSA;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PAUSA: begin
                tmr_dec = 1'b1;
            end
        endcase
    end

    robo_temporizador #(
        .CNT_W(CNT_W)
    ) u_temporizador (
        .clock        (clock),
        .reset        (reset),
        .carga_i      (tmr_carga),
        .valor_carga_i(tmr_valor_carga),
        .dec_i        (tmr_dec),
        .valor_o      (tmr_valor),
        .zero_o       (tmr_zero)
    );

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            abortado_q <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            abortado_q <= 1'b0;
            erro_q     <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (aceita) begin
                        abort_q <= 1'b0;
                        if (cmd_girar) begin
                            estado_q <= GIRANDO;
                        end else if (cmd_avancar) begin
                            estado_q <= AVANCANDO;
                        end else begin
                            done_q <= 1'b1;
                            erro_q <= 1'b1;
                        end
                    end
                end
                AVANCANDO: begin
                    // head wins over the last timed cycle: the move still counts as aborted.
                    if (head) begin
                        abort_q  <= 1'b1;
                        estado_q <= PAUSA;
                    end else if (tmr_zero) begin
                        estado_q <= PAUSA;
                    end
                end
                GIRANDO: begin
                    if (tmr_zero) begin
                        estado_q <= PAUSA;
                    end
                end
                PAUSA: begin
                    if (tmr_zero) begin
                        estado_q   <= OCIOSO;
                        done_q     <= 1'b1;
                        abortado_q <= abort_q;
                    end
                end
            endcase
        end
    end

    assign done     = done_q;
    assign abortado = abortado_q;
    assign cmd_erro = erro_q;

    // The settle timer is always loaded with the pause length on entry to PAUSA.
    always_comb begin
        if (estado_q == PAUSA) begin
            assert (tmr_valor <= CARGA_PAUSA);
        end
    end

`ifdef ROBO_WATCHDOG_EN
    logic       frente_q;
    logic [1:0] cont_abort_q;
    logic       travado_q;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            frente_q     <= 1'b0;
            cont_abort_q <= 2'd0;
            travado_q    <= 1'b0;
        end else begin
            if (aceita) begin
                frente_q <= !cmd_girar && cmd_avancar;
            end
            if ((estado_q == PAUSA) && tmr_zero && frente_q) begin
                if (abort_q) begin
                    if (cont_abort_q != 2'd3) begin
                        cont_abort_q <= cont_abort_q + 2'd1;
                    end
                    if (cont_abort_q >= 2'd2) begin
                        travado_q <= 1'b1;
                    end
                end else begin
                    cont_abort_q <= 2'd0;
                    travado_q    <= 1'b0;
                end
            end
        end
    end

    assign travado = travado_q;
`else
    assign travado = 1'b0;
`endif

endmodule
